// File: rtl/apb_regfile_slave.sv
// APB completer fronting a small register bank: ID (RO), WAIT_CFG (RW, 4 bits)
// and NREGS data words. Programmable wait states and registered responses.
// Optional macro APB_PSTRB_EN adds a pstrb port for byte-lane write masking.
module apb_regfile_slave #(
  parameter int unsigned NREGS        = 8,
  parameter int unsigned WAIT_DEFAULT = 0,
  parameter logic [31:0] ID_VALUE     = 32'hA5B0_0001
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
`ifdef APB_PSTRB_EN
  input  logic [3:0]  pstrb,
`endif
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam int unsigned IdxW     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [31:0] LastAddr = 32'(8 + 4 * (NREGS - 1));
  localparam logic [3:0]  WaitRst  = 4'(WAIT_DEFAULT);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_addr, r_wdata;
  logic        r_write;
  logic        r_pready, r_pslverr;
  logic [31:0] r_prdata;
  logic [3:0]  r_wait_cfg;
  logic [31:0] r_data [NREGS];
`ifdef APB_PSTRB_EN
  logic [3:0]  r_strb;
`endif

  logic            w_setup;
  logic [31:0]     w_addr;
  logic            w_write;
  logic            w_is_id, w_is_cfg, w_is_data, w_err;
  logic [IdxW-1:0] w_idx, w_widx;
  logic [31:0]     w_rdata;
  logic [31:0]     w_mask;
  logic            w_cfg_we;

  // Next-state logic: setup in IDLE starts a transfer, psel loss in WAIT aborts it.
  always_comb begin
    w_setup      = psel && !penable;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_setup) begin
          if (r_wait_cfg == 4'd0) begin
            w_state_next = StDone;
          end else begin
            w_cnt_next   = r_wait_cfg - 4'd1;
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        if (!psel) begin
          w_state_next = StIdle;
        end else if (r_cnt == 4'd0) begin
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Address decode; in IDLE the live bus is used since the latch has not happened yet.
  always_comb begin
    w_addr    = (r_state == StIdle) ? paddr : r_addr;
    w_write   = (r_state == StIdle) ? pwrite : r_write;
    w_is_id   = (w_addr == 32'h0);
    w_is_cfg  = (w_addr == 32'h4);
    w_is_data = (w_addr >= 32'h8) && (w_addr <= LastAddr);
    w_err     = (w_addr[1:0] != 2'b00) || !(w_is_id || w_is_cfg || w_is_data)
                || (w_write && w_is_id);
    w_idx     = IdxW'(w_addr[31:2] - 30'd2);
    w_widx    = IdxW'(r_addr[31:2] - 30'd2);
    w_rdata   = 32'h0;
    if (w_is_id) begin
      w_rdata = ID_VALUE;
    end else if (w_is_cfg) begin
      w_rdata = {28'h0, r_wait_cfg};
    end else if (w_is_data) begin
      w_rdata = r_data[w_idx];
    end
`ifdef APB_PSTRB_EN
    w_mask   = {{8{r_strb[3]}}, {8{r_strb[2]}}, {8{r_strb[1]}}, {8{r_strb[0]}}};
    w_cfg_we = r_strb[0];
`else
    w_mask   = 32'hFFFF_FFFF;
    w_cfg_we = 1'b1;
`endif
  end

  // FSM state, setup-phase latches and registered response outputs.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_addr    <= 32'h0;
      r_write   <= 1'b0;
      r_wdata   <= 32'h0;
`ifdef APB_PSTRB_EN
      r_strb    <= 4'h0;
`endif
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if ((r_state == StIdle) && w_setup) begin
        r_addr  <= paddr;
        r_write <= pwrite;
        r_wdata <= pwdata;
`ifdef APB_PSTRB_EN
        r_strb  <= pstrb;
`endif
      end
      r_pready  <= (w_state_next == StDone);
      r_pslverr <= (w_state_next == StDone) && w_err;
      r_prdata  <= ((w_state_next == StDone) && !w_err && !w_write) ? w_rdata : 32'h0;
    end
  end

  // Register bank; writes commit on the edge that ends DONE (r_pslverr holds its error).
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_wait_cfg <= WaitRst;
      for (int i = 0; i < int'(NREGS); i++) begin
        r_data[i] <= 32'h0;
      end
    end else if ((r_state == StDone) && r_write && !r_pslverr) begin
      if (r_addr == 32'h4) begin
        if (w_cfg_we) begin
          r_wait_cfg <= r_wdata[3:0];
        end
      end else if (r_addr >= 32'h8) begin
        r_data[w_widx] <= (r_data[w_widx] & ~w_mask) | (r_wdata & w_mask);
      end
    end
  end

  assign pready  = r_pready;
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave: a reference model predicts each
// response into a scoreboard queue, which is popped when pready is observed.
module tb_apb_regfile_slave;

  localparam int unsigned NREGS = 8;
  localparam logic [31:0] IDV   = 32'hA5B0_0001;
  localparam int          TMO   = 40;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = 32'h0, pwdata = 32'h0;
`ifdef APB_PSTRB_EN
  logic [3:0]  pstrb = 4'hF;
`endif
  logic        pready, pslverr;
  logic [31:0] prdata;

  always #5 pclk = ~pclk;

  apb_regfile_slave #(.NREGS(NREGS), .WAIT_DEFAULT(0), .ID_VALUE(IDV)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
`ifdef APB_PSTRB_EN
    .pstrb   (pstrb),
`endif
    .pready  (pready),
    .prdata  (prdata),
    .pslverr (pslverr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        is_read;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [NREGS];
  logic [3:0]  m_wait;

  function automatic logic [3:0] cur_strb();
`ifdef APB_PSTRB_EN
    return pstrb;
`else
    return 4'hF;
`endif
  endfunction

  // Reference model: predicts the response and applies the write to the model.
  function automatic exp_t predict(input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_t        e;
    logic        id, wc, dt;
    logic [31:0] m;
    logic [3:0]  s;
    int          k;
    s  = cur_strb();
    m  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    id = (a == 32'h0);
    wc = (a == 32'h4);
    dt = (a >= 32'h8) && (a <= 32'(8 + 4 * (NREGS - 1)));
    e.err     = (a[1:0] != 2'b00) || !(id || wc || dt) || (w && id);
    e.lat     = int'(m_wait) + 1;
    e.is_read = !w;
    e.rdata   = 32'h0;
    k = int'((a - 32'h8) >> 2);
    if (!e.err) begin
      if (w) begin
        if (wc && s[0]) m_wait = d[3:0];
        if (dt) mem[k] = (mem[k] & ~m) | (d & m);
      end else begin
        e.rdata = id ? IDV : (wc ? {28'h0, m_wait} : mem[k]);
      end
    end
    return e;
  endfunction

  // Entered and left at #1 after a rising edge, so consecutive calls are back-to-back.
  task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        rd = prdata; er = pslverr; lat = i;
        break;
      end
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat; exp_t e;
    presetn = 1'b0;
    for (int i = 0; i < NREGS; i++) mem[i] = 32'h0;
    m_wait = 4'd0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checks++;
    if ({pready, pslverr, prdata} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%0b/%0b/%h exp=0/0/0", pready, pslverr, prdata);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    sb.push_back(predict(32'h0, 1'b0, 32'h0));
    apb_xfer(32'h0, 1'b0, 32'h0, rd, er, lat);
    e = sb.pop_front();
    checks += 3;
    if (rd !== e.rdata) begin failures++; $display("FAIL reset_id_rdata got=%h exp=%h", rd, e.rdata); end
    if (er !== e.err) begin failures++; $display("FAIL reset_id_err got=%0b exp=%0b", er, e.err); end
    if (lat != e.lat) begin failures++; $display("FAIL reset_id_lat got=%0d exp=%0d", lat, e.lat); end
  endtask

  task automatic test_wait_states();
    logic [31:0] ta [6] = '{32'h4, 32'h8, 32'h8, 32'h4, 32'h4, 32'h4};
    logic        tw [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] td [6] = '{32'h3, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFF2, 32'h0, 32'h0};
    logic [31:0] rd; logic er; int lat; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(predict(ta[i], tw[i], td[i]));
      apb_xfer(ta[i], tw[i], td[i], rd, er, lat);
      e = sb.pop_front();
      checks += 2;
      if (er !== e.err) begin failures++; $display("FAIL wait_err[%0d] got=%0b exp=%0b", i, er, e.err); end
      if (lat != e.lat) begin failures++; $display("FAIL wait_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
      if (e.is_read) begin
        checks++;
        if (rd !== e.rdata) begin failures++; $display("FAIL wait_rdata[%0d] got=%h exp=%h", i, rd, e.rdata); end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ta [6] = '{32'h0, 32'h0, 32'hA, 32'(8 + 4 * NREGS), 32'h9, 32'h8};
    logic        tw [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] td [6] = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h5555_5555, 32'h0};
    logic [31:0] rd; logic er; int lat; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(predict(ta[i], tw[i], td[i]));
      apb_xfer(ta[i], tw[i], td[i], rd, er, lat);
      e = sb.pop_front();
      checks += 2;
      if (er !== e.err) begin failures++; $display("FAIL err_flag[%0d] got=%0b exp=%0b", i, er, e.err); end
      if (lat != e.lat) begin failures++; $display("FAIL err_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
      if (e.is_read) begin
        checks++;
        if (rd !== e.rdata) begin failures++; $display("FAIL err_rdata[%0d] got=%h exp=%h", i, rd, e.rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, d; logic er; int lat; exp_t e;
    for (int k = 0; k < NREGS; k++) begin
      for (int r = 0; r < 2; r++) begin
        d = $urandom() ^ (32'h0101_0101 * k);
        sb.push_back(predict(32'(8 + 4 * k), r == 0, d));
        apb_xfer(32'(8 + 4 * k), r == 0, d, rd, er, lat);
        e = sb.pop_front();
        checks += 2;
        if (er !== e.err || lat != e.lat) begin
          failures++;
          $display("FAIL b2b_resp[%0d.%0d] got=%0b/%0d exp=%0b/%0d", k, r, er, lat, e.err, e.lat);
        end
        if (e.is_read && rd !== e.rdata) begin
          failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", k, rd, e.rdata);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int lat; exp_t e; int seen;
    sb.push_back(predict(32'h4, 1'b1, 32'h5));
    apb_xfer(32'h4, 1'b1, 32'h5, rd, er, lat);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat) begin failures++; $display("FAIL abort_cfg_lat got=%0d exp=%0d", lat, e.lat); end
    // Write to DATA[1] that is abandoned after two access cycles; model stays untouched.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hBAD0_BAD0;
    @(posedge pclk); #1;
    penable = 1'b1;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk); if (pready) seen++;
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk); if (pready) seen++;
    end
    @(posedge pclk); #1;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_pready got=%0d exp=0", seen); end
    sb.push_back(predict(32'hC, 1'b0, 32'h0));
    apb_xfer(32'hC, 1'b0, 32'h0, rd, er, lat);
    e = sb.pop_front();
    checks += 2;
    if (rd !== e.rdata) begin failures++; $display("FAIL abort_rdata got=%h exp=%h", rd, e.rdata); end
    if (lat != e.lat) begin failures++; $display("FAIL abort_lat got=%0d exp=%0d", lat, e.lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; exp_t e;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1234_5678;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b0;
    @(negedge pclk);
    @(posedge pclk); #1;
    presetn = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    checks++;
    if ({pready, pslverr, prdata} !== 34'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%0b/%0b/%h exp=0/0/0", pready, pslverr, prdata);
    end
    for (int i = 0; i < NREGS; i++) mem[i] = 32'h0;
    m_wait = 4'd0;
    @(posedge pclk); #1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(predict(i == 0 ? 32'h4 : 32'h10, 1'b0, 32'h0));
      apb_xfer(i == 0 ? 32'h4 : 32'h10, 1'b0, 32'h0, rd, er, lat);
      e = sb.pop_front();
      checks += 2;
      if (rd !== e.rdata) begin failures++; $display("FAIL rstmid_rdata[%0d] got=%h exp=%h", i, rd, e.rdata); end
      if (lat != e.lat) begin failures++; $display("FAIL rstmid_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
    end
  endtask

`ifdef APB_PSTRB_EN
  task automatic test_pstrb();
    logic [31:0] ta [6] = '{32'h8, 32'h8, 32'h8, 32'h8, 32'h4, 32'h4};
    logic        tw [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] td [6] = '{32'h1122_3344, 32'hAABB_CCDD, 32'hFFFF_FFFF, 32'h0, 32'h7, 32'h0};
    logic [3:0]  ts [6] = '{4'hF, 4'b0101, 4'h0, 4'hF, 4'b1110, 4'hF};
    logic [31:0] rd; logic er; int lat; exp_t e;
    for (int i = 0; i < 6; i++) begin
      pstrb = ts[i];
      sb.push_back(predict(ta[i], tw[i], td[i]));
      apb_xfer(ta[i], tw[i], td[i], rd, er, lat);
      e = sb.pop_front();
      checks += 2;
      if (er !== e.err) begin failures++; $display("FAIL strb_err[%0d] got=%0b exp=%0b", i, er, e.err); end
      if (lat != e.lat) begin failures++; $display("FAIL strb_lat[%0d] got=%0d exp=%0d", i, lat, e.lat); end
      if (e.is_read) begin
        checks++;
        if (rd !== e.rdata) begin failures++; $display("FAIL strb_rdata[%0d] got=%h exp=%h", i, rd, e.rdata); end
      end
    end
    pstrb = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef APB_PSTRB_EN
    test_pstrb();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
